// File: rtl/cam_disp_pkg.sv
// Shared constants and types for the multi-camera display controller:
// 640x480@60 raster timing, layout selection and PIP window placement.
package cam_disp_pkg;

  // Horizontal raster (pixel clocks per line)
  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] H_TOTAL      = 10'd800;

  // Vertical raster (lines per frame)
  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;
  localparam logic [9:0] V_TOTAL      = 10'd525;

  // Screen split points used by SPLIT and QUAD layouts
  localparam logic [9:0] HALF_X   = 10'd320;
  localparam logic [9:0] HALF_Y   = 10'd240;
  localparam logic [9:0] SPLIT_Y0 = 10'd120;
  localparam logic [9:0] SPLIT_Y1 = 10'd359;

  // Picture-in-picture inset window, inclusive bounds, shown at x1 scale
  localparam logic [9:0] PIP_X0 = 10'd472;
  localparam logic [9:0] PIP_X1 = 10'd631;
  localparam logic [9:0] PIP_Y0 = 10'd8;
  localparam logic [9:0] PIP_Y1 = 10'd127;

  typedef enum logic [1:0] {
    LAYOUT_SINGLE = 2'd0,
    LAYOUT_SPLIT  = 2'd1,
    LAYOUT_QUAD   = 2'd2,
    LAYOUT_PIP    = 2'd3
  } layout_e;

  // Video control signals that travel alongside the pixel pipeline
  typedef struct packed {
    logic       de;
    logic       h_sync;
    logic       v_sync;
    logic       frame_start;
    logic [9:0] x;
    logic [9:0] y;
  } vid_ctl_t;

  localparam vid_ctl_t VID_CTL_RST = '{
    de: 1'b0, h_sync: 1'b1, v_sync: 1'b1, frame_start: 1'b0, x: 10'd0, y: 10'd0
  };

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running 800x525 raster counter with active-low sync generation.
// All outputs are decoded from the current counter position (cycle t).
module vga_timing_gen
  import cam_disp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [9:0] h_cnt_o,
  output logic [9:0] v_cnt_o,
  output logic       de_o,
  output logic       h_sync_o,
  output logic       v_sync_o,
  output logic       frame_start_o,
  output logic       frame_end_o
);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       h_last;
  logic       v_last;

  assign h_last = (h_q == H_TOTAL - 10'd1);
  assign v_last = (v_q == V_TOTAL - 10'd1);

  // Next raster position: h wraps every line, v steps (and wraps) on h wrap
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + 10'd1;
    end
  end

  // Raster position registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o       = h_q;
  assign v_cnt_o       = v_q;
  assign de_o          = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
  assign h_sync_o      = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
  assign v_sync_o      = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
  assign frame_start_o = (h_q == '0) && (v_q == '0);
  assign frame_end_o   = h_last && v_last;

endmodule

// File: rtl/multi_cam_display_ctrl.sv
// Multi-camera display compositor. Reads up to four frame buffers through
// one shared address and composes SINGLE / SPLIT / QUAD / PIP layouts onto
// a 640x480 raster. Pipeline: counters (t), address + select (t+1),
// frame-buffer data (t+2), pixel out (t+3); control signals ride along.
module multi_cam_display_ctrl
  import cam_disp_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  localparam int AW        = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode_req,
  input  logic [1:0]            main_sel,
  input  logic [1:0]            pip_sel,
  output logic [AW-1:0]         rAddr,
  input  logic [NUM_CH*16-1:0]  rData,
  output logic [15:0]           rgb_out,
  output logic                  DE,
  output logic                  h_sync,
  output logic                  v_sync,
  output logic [9:0]            x_pixel,
  output logic [9:0]            y_pixel,
  output logic                  frame_start
);

  localparam logic [15:0] W_BITS   = 16'(IMG_WIDTH);
  localparam logic [2:0]  NUM_CH_L = 3'(NUM_CH);

  // Row * IMG_WIDTH as a sum of shifted copies of the row index; the
  // caller only uses it for rows inside the source image, so it fits AW.
  function automatic logic [AW-1:0] row_base(input logic [9:0] r);
    logic [AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (W_BITS[i]) acc = acc + (AW'(r) << i);
    end
    return acc;
  endfunction

  // ---------------- raster timing ----------------
  logic [9:0] h_cnt, v_cnt;
  logic       t_de, t_hs, t_vs, t_fs, t_fe;

  vga_timing_gen u_timing (
    .clk_i         (clk),
    .rst_ni        (reset),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .de_o          (t_de),
    .h_sync_o      (t_hs),
    .v_sync_o      (t_vs),
    .frame_start_o (t_fs),
    .frame_end_o   (t_fe)
  );

  // ---------------- layout shadow registers ----------------
  layout_e    mode_q, mode_d;
  logic [1:0] main_q, main_d;
  logic [1:0] pip_q, pip_d;

  // Layout requests are only accepted on the last pixel of a frame
  always_comb begin
    mode_d = mode_q;
    main_d = main_q;
    pip_d  = pip_q;
    if (t_fe) begin
      mode_d = layout_e'(mode_req);
      main_d = main_sel;
      pip_d  = pip_sel;
    end
  end

  // Shadow registers hold the layout for the whole current frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q <= LAYOUT_SINGLE;
      main_q <= '0;
      pip_q  <= '0;
    end else begin
      mode_q <= mode_d;
      main_q <= main_d;
      pip_q  <= pip_d;
    end
  end

  // ---------------- address / channel decode ----------------
  logic [9:0]    x_mod, y_mod;
  logic          in_pip;
  logic [9:0]    row, col;
  logic [1:0]    ch_d;
  logic          black;
  logic          in_range;
  logic [AW-1:0] addr_d;
  logic          blank_d;

  assign x_mod  = (h_cnt >= HALF_X) ? h_cnt - HALF_X : h_cnt;
  assign y_mod  = (v_cnt >= HALF_Y) ? v_cnt - HALF_Y : v_cnt;
  assign in_pip = (h_cnt >= PIP_X0) && (h_cnt <= PIP_X1) &&
                  (v_cnt >= PIP_Y0) && (v_cnt <= PIP_Y1);

  // Map the raster position to a source channel and source row/column
  always_comb begin
    row   = '0;
    col   = '0;
    ch_d  = '0;
    black = 1'b1;
    if (t_de) begin
      black = 1'b0;
      case (mode_q)
        LAYOUT_SPLIT: begin
          if ((v_cnt >= SPLIT_Y0) && (v_cnt <= SPLIT_Y1)) begin
            ch_d = {1'b0, h_cnt >= HALF_X};
            row  = (v_cnt - SPLIT_Y0) >> 1;
            col  = x_mod >> 1;
          end else begin
            black = 1'b1;
          end
        end
        LAYOUT_QUAD: begin
          ch_d = {v_cnt >= HALF_Y, h_cnt >= HALF_X};
          row  = y_mod >> 1;
          col  = x_mod >> 1;
        end
        LAYOUT_PIP: begin
          if (in_pip) begin
            ch_d = pip_q;
            row  = v_cnt - PIP_Y0;
            col  = h_cnt - PIP_X0;
          end else begin
            ch_d = main_q;
            row  = v_cnt >> 2;
            col  = h_cnt >> 2;
          end
        end
        default: begin
          ch_d = main_q;
          row  = v_cnt >> 2;
          col  = h_cnt >> 2;
        end
      endcase
    end
  end

  // Rows/columns beyond the source image are shown black, never addressed
  assign in_range = ({22'b0, row} < 32'(IMG_HEIGHT)) && ({22'b0, col} < 32'(IMG_WIDTH));
  assign addr_d   = (black || !in_range) ? '0 : row_base(row) + AW'(col);
  assign blank_d  = black || !in_range || ({1'b0, ch_d} >= NUM_CH_L);

  // ---------------- pipeline ----------------
  vid_ctl_t      ctl0, ctl1_q, ctl2_q, ctl3_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    ch1_q, ch2_q;
  logic          blank1_q, blank2_q;
  logic [15:0]   pix_d, rgb_q;

  // Pack the raster control signals for the current position
  always_comb begin
    ctl0             = VID_CTL_RST;
    ctl0.de          = t_de;
    ctl0.h_sync      = t_hs;
    ctl0.v_sync      = t_vs;
    ctl0.frame_start = t_fs;
    ctl0.x           = h_cnt;
    ctl0.y           = v_cnt;
  end

  // Stage 1: shared frame-buffer address and channel decision
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q   <= '0;
      ch1_q    <= '0;
      blank1_q <= 1'b1;
      ctl1_q   <= VID_CTL_RST;
    end else begin
      addr_q   <= addr_d;
      ch1_q    <= ch_d;
      blank1_q <= blank_d;
      ctl1_q   <= ctl0;
    end
  end

  // Stage 2: wait out the frame-buffer read latency
  always_ff @(posedge clk) begin
    if (!reset) begin
      ch2_q    <= '0;
      blank2_q <= 1'b1;
      ctl2_q   <= VID_CTL_RST;
    end else begin
      ch2_q    <= ch1_q;
      blank2_q <= blank1_q;
      ctl2_q   <= ctl1_q;
    end
  end

  // Pick the selected channel's word out of the read data
  always_comb begin
    pix_d = '0;
    if (!blank2_q) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch2_q == 2'(k)) pix_d = rData[16*k +: 16];
      end
    end
  end

  // Stage 3: registered pixel and aligned control outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_q  <= '0;
      ctl3_q <= VID_CTL_RST;
    end else begin
      rgb_q  <= pix_d;
      ctl3_q <= ctl2_q;
    end
  end

  assign rAddr       = addr_q;
  assign rgb_out     = rgb_q;
  assign DE          = ctl3_q.de;
  assign h_sync      = ctl3_q.h_sync;
  assign v_sync      = ctl3_q.v_sync;
  assign frame_start = ctl3_q.frame_start;
  assign x_pixel     = ctl3_q.x;
  assign y_pixel     = ctl3_q.y;

endmodule

// File: tb/tb_multi_cam_display_ctrl.sv
// Bench for multi_cam_display_ctrl: behavioural frame buffers, a raster
// reference model built from the layout rules, and latency queues.
module tb_multi_cam_display_ctrl;

  localparam int NUM_CH = 2;
  localparam int IMG_W  = 160;
  localparam int IMG_H  = 120;
  localparam int AW     = 15;
  localparam int FRAME  = 800 * 525;
  localparam int MAX_FAIL = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic                 reset;
  logic [1:0]           mode_req, main_sel, pip_sel;
  logic [AW-1:0]        rAddr;
  logic [NUM_CH*16-1:0] rData;
  logic [15:0]          rgb_out;
  logic                 DE, h_sync, v_sync, frame_start;
  logic [9:0]           x_pixel, y_pixel;

  multi_cam_display_ctrl #(
    .NUM_CH     (NUM_CH),
    .IMG_WIDTH  (IMG_W),
    .IMG_HEIGHT (IMG_H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode_req    (mode_req),
    .main_sel    (main_sel),
    .pip_sel     (pip_sel),
    .rAddr       (rAddr),
    .rData       (rData),
    .rgb_out     (rgb_out),
    .DE          (DE),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .x_pixel     (x_pixel),
    .y_pixel     (y_pixel),
    .frame_start (frame_start)
  );

  // ---------------- frame buffer model ----------------
  logic [15:0] salt;

  function automatic logic [15:0] pat(input int k, input int a);
    return 16'(a * 40503 + k * 9973) ^ salt;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) rData[16*k +: 16] <= pat(k, int'(rAddr));
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int cur_c  = -1;

  logic [39:0]   exp_q[$];
  logic [AW-1:0] addr_exp_q[$];
  localparam logic [39:0] VID_RST = {16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0};

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cur_c, obs, exp_v);
    end
  endtask

  // Layout config in force for each frame since the last reset
  int cfg_mode[8], cfg_main[8], cfg_pip[8];
  int plan_mode[8], plan_main[8], plan_pip[8];

  // Reference: expected shared address and video word for raster position p
  function automatic void model(input int f, input int p,
                                output logic [AW-1:0] a_exp, output logic [39:0] v_exp);
    int x, y, m, ch, addr;
    bit blk;
    logic [15:0] rgb;
    x = p % 800;
    y = p / 800;
    m = cfg_mode[f];
    ch = 0; addr = 0; blk = 1;
    if (x < 640 && y < 480) begin
      blk = 0;
      if (m == 3 && x >= 472 && x <= 631 && y >= 8 && y <= 127) begin
        ch = cfg_pip[f];
        addr = (y - 8) * IMG_W + (x - 472);
      end else if (m == 0 || m == 3) begin
        ch = cfg_main[f];
        addr = (y / 4) * IMG_W + x / 4;
      end else if (m == 1) begin
        if (y >= 120 && y < 360) begin
          ch = (x >= 320) ? 1 : 0;
          addr = ((y - 120) / 2) * IMG_W + (x % 320) / 2;
        end else begin
          blk = 1;
        end
      end else begin
        ch = (y / 240) * 2 + (x / 320);
        addr = ((y % 240) / 2) * IMG_W + (x % 320) / 2;
      end
    end
    a_exp = AW'(addr);
    rgb = (blk || ch >= NUM_CH) ? 16'h0000 : pat(ch, addr);
    v_exp = {rgb, 1'(x < 640 && y < 480), 1'(!(x >= 656 && x <= 751)),
             1'(!(y >= 490 && y <= 491)), 1'(x == 0 && y == 0), 10'(x), 10'(y)};
  endfunction

  // ---------------- driver tasks ----------------
  int c;

  task automatic drive_random();
    mode_req = 2'($urandom_range(0, 3));
    main_sel = 2'($urandom_range(0, 3));
    pip_sel  = 2'($urandom_range(0, 3));
  endtask

  // Called on a negedge while the DUT sits in reset; releases reset
  task automatic begin_run();
    c = 0;
    for (int i = 0; i < 8; i++) begin
      cfg_mode[i] = 0; cfg_main[i] = 0; cfg_pip[i] = 0;
    end
    exp_q.delete();
    addr_exp_q.delete();
    repeat (3) exp_q.push_back(VID_RST);
    addr_exp_q.push_back('0);
    reset = 1'b1;
  endtask

  // One cycle: compare against queued expectations, queue the current
  // position, drive inputs (planned value on a frame's last pixel)
  task automatic step();
    logic [AW-1:0] a_exp;
    logic [39:0]   v_exp;
    int f, p;
    cur_c = c;
    check_val("video", 64'({rgb_out, DE, h_sync, v_sync, frame_start, x_pixel, y_pixel}),
              64'(exp_q.pop_front()));
    check_val("rAddr", 64'(rAddr), 64'(addr_exp_q.pop_front()));
    f = c / FRAME;
    p = c % FRAME;
    model(f, p, a_exp, v_exp);
    exp_q.push_back(v_exp);
    addr_exp_q.push_back(a_exp);
    if (p == FRAME - 1 && f + 1 < 8) begin
      mode_req = 2'(plan_mode[f+1]);
      main_sel = 2'(plan_main[f+1]);
      pip_sel  = 2'(plan_pip[f+1]);
      cfg_mode[f+1] = plan_mode[f+1];
      cfg_main[f+1] = plan_main[f+1];
      cfg_pip[f+1]  = plan_pip[f+1];
    end else begin
      drive_random();
    end
    c++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n && n_fail <= MAX_FAIL; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rAddr"}, 64'(rAddr), 64'(0));
    check_val({tag, "_rgb"}, 64'(rgb_out), 64'(0));
    check_val({tag, "_de"}, 64'(DE), 64'(0));
    check_val({tag, "_hsync"}, 64'(h_sync), 64'(1));
    check_val({tag, "_vsync"}, 64'(v_sync), 64'(1));
    check_val({tag, "_x"}, 64'(x_pixel), 64'(0));
    check_val({tag, "_y"}, 64'(y_pixel), 64'(0));
    check_val({tag, "_fs"}, 64'(frame_start), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    salt  = 16'($urandom);
    reset = 1'b0;
    drive_random();
    for (int i = 0; i < 8; i++) begin
      plan_mode[i] = 0; plan_main[i] = 0; plan_pip[i] = 0;
    end
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");

    // Frame 0 runs as SINGLE ch0; abort it with a one-cycle reset at (300,100)
    begin_run();
    run(100 * 800 + 300);
    reset = 1'b0;
    @(negedge clk);
    cur_c = -1;
    check_reset_outputs("abort");

    // Restart and step through QUAD, SPLIT and PIP frames
    plan_mode[1] = 2; plan_main[1] = $urandom_range(0, 3); plan_pip[1] = $urandom_range(0, 3);
    plan_mode[2] = 1; plan_main[2] = $urandom_range(0, 3); plan_pip[2] = $urandom_range(0, 3);
    plan_mode[3] = 3; plan_main[3] = 1;                    plan_pip[3] = 0;
    begin_run();
    run(3 * FRAME + 135 * 800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
